// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding and START/STOP detect helpers.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  // START and STOP are SDA edges seen while SCL sits at this level.
  localparam logic       COND_SCL_LEVEL = 1'b1;
  localparam logic [3:0] BITS_PER_BYTE  = 4'd8;
  localparam logic [3:0] LAST_BIT       = 4'd7;

  function automatic logic is_start(input logic scl_lvl, input logic sda_fall);
    return sda_fall && (scl_lvl == COND_SCL_LEVEL);
  endfunction

  function automatic logic is_stop(input logic scl_lvl, input logic sda_rise);
    return sda_rise && (scl_lvl == COND_SCL_LEVEL);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one bus line plus rise/fall pulses on the synchronized level.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], d};
      prev_reg <= sync_reg[1];
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~prev_reg;
  assign fall  = ~sync_reg[1] & prev_reg;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with byte-wide write/read handshake. Clock stretching (stretch/scl_oe ports)
// is compiled in only when I2C_SLAVE_STRETCH_EN is defined.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h05
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done
`ifdef I2C_SLAVE_STRETCH_EN
  ,
  input  logic       stretch,
  output logic       scl_oe
`endif
);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] line_raw, line_lvl, line_rise, line_fall;
  assign line_raw = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      i2c_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (line_raw[gi]),
        .level(line_lvl[gi]),
        .rise (line_rise[gi]),
        .fall (line_fall[gi])
      );
    end
  endgenerate

  logic scl_lvl, scl_rise, scl_fall, sda_lvl, start_det, stop_det;
  assign scl_lvl   = line_lvl[0];
  assign scl_rise  = line_rise[0];
  assign scl_fall  = line_fall[0];
  assign sda_lvl   = line_lvl[1];
  assign start_det = is_start(scl_lvl, line_fall[1]);
  assign stop_det  = is_stop(scl_lvl, line_rise[1]);

  i2c_state_t state_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [6:0] tx_reg;
  logic       rw_reg, nack_reg;
  logic       sda_oe_reg, wr_valid_reg, rd_req_reg, busy_reg, done_reg;
  logic [7:0] wr_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'd0;
      tx_reg       <= 7'd0;
      rw_reg       <= 1'b0;
      nack_reg     <= 1'b0;
      sda_oe_reg   <= 1'b0;
      wr_data_reg  <= 8'd0;
      wr_valid_reg <= 1'b0;
      rd_req_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      wr_valid_reg <= 1'b0;
      rd_req_reg   <= 1'b0;
      done_reg     <= 1'b0;
      if (stop_det) begin
        state_reg   <= IDLE;
        bit_cnt_reg <= 4'd0;
        sda_oe_reg  <= 1'b0;
        busy_reg    <= 1'b0;
        done_reg    <= busy_reg;
      end else if (start_det) begin
        state_reg   <= ADDR;
        bit_cnt_reg <= 4'd0;
        sda_oe_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ADDR: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_lvl};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && bit_cnt_reg == BITS_PER_BYTE) begin
              bit_cnt_reg <= 4'd0;
              if (shift_reg[7:1] == SLV_ADDR) begin
                state_reg  <= ADDR_ACK;
                sda_oe_reg <= 1'b1;
                busy_reg   <= 1'b1;
                rw_reg     <= shift_reg[0];
              end else begin
                state_reg <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_reg) begin
                state_reg  <= RD_DATA;
                rd_req_reg <= 1'b1;
              end else begin
                state_reg  <= WR_DATA;
                sda_oe_reg <= 1'b0;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_lvl};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == LAST_BIT) begin
                wr_valid_reg <= 1'b1;
                wr_data_reg  <= {shift_reg[6:0], sda_lvl};
              end
            end else if (scl_fall && bit_cnt_reg == BITS_PER_BYTE) begin
              state_reg   <= WR_ACK;
              sda_oe_reg  <= 1'b1;
              bit_cnt_reg <= 4'd0;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state_reg  <= WR_DATA;
              sda_oe_reg <= 1'b0;
            end
          end
          RD_DATA: begin
            // rd_data is taken in the cycle rd_req is high; MSB goes out immediately.
            if (rd_req_reg) begin
              tx_reg      <= rd_data[6:0];
              sda_oe_reg  <= ~rd_data[7];
              bit_cnt_reg <= 4'd0;
            end else if (scl_fall) begin
              if (bit_cnt_reg == LAST_BIT) begin
                state_reg   <= RD_ACK;
                sda_oe_reg  <= 1'b0;
                bit_cnt_reg <= 4'd0;
              end else begin
                sda_oe_reg  <= ~tx_reg[6];
                tx_reg      <= {tx_reg[5:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              nack_reg <= sda_lvl;
            end else if (scl_fall) begin
              if (nack_reg) begin
                state_reg <= WAIT_STOP;
              end else begin
                state_reg  <= RD_DATA;
                rd_req_reg <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign wr_data  = wr_data_reg;
  assign wr_valid = wr_valid_reg;
  assign rd_req   = rd_req_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

`ifdef I2C_SLAVE_STRETCH_EN
  logic scl_oe_reg;

  // Grab SCL only once the master has driven it low; hold until stretch drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_oe_reg <= 1'b0;
    end else begin
      scl_oe_reg <= stretch && busy_reg && (state_reg != IDLE) && (state_reg != WAIT_STOP)
                    && (!scl_lvl || scl_oe_reg);
    end
  end

  assign scl_oe = scl_oe_reg;
`endif

endmodule
